// File: rtl/router_fifo_if.sv
// router_fifo_if
// Groups the write/read handshake and data bus of the router FIFO.
//   soft_reset : synchronous flush from the sync stage (read timeout)
//   write_enb  : write strobe
//   read_enb   : read strobe from the output port consumer
//   lfd_state  : current write word is a packet header
//   data_in    : write data (header: [7:2] length, [1:0] address)
//   data_out   : registered read data
//   empty      : no stored words
//   full       : 16 words stored
// Modports: master drives strobes and write data; slave is the FIFO.
interface router_fifo_if;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       empty;
    logic       full;

    modport master (
        output soft_reset, write_enb, read_enb, lfd_state, data_in,
        input  data_out, empty, full
    );

    modport slave (
        input  soft_reset, write_enb, read_enb, lfd_state, data_in,
        output data_out, empty, full
    );
endinterface

// File: rtl/router_fifo.sv
// router_fifo
// 16-entry x 9-bit packet FIFO for one router output port. Bit 8 of each
// entry records whether the word was a header; a 7-bit packet counter tracks
// the bytes still to be delivered so that data_out idles between packets.
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   fifo   : router_fifo_if.slave (soft_reset, write_enb, read_enb,
//            lfd_state, data_in, data_out, empty, full)
// Configuration:
//   ROUTER_FIFO_TRISTATE_EN : when defined, the idle value of data_out is
//                             high impedance; otherwise it is 8'h00.
module router_fifo (
    input  logic          clock,
    input  logic          resetn,
    router_fifo_if.slave  fifo
);

    logic [8:0] mem [16];
    logic [4:0] wr_ptr;
    logic [4:0] rd_ptr;
    logic [6:0] pkt_count;
    logic [7:0] data_q;
    logic       out_valid;
    logic       wr_acc;
    logic       rd_acc;
    logic [8:0] rd_entry;

    // Bit 4 of each pointer is a wrap marker so equal indexes can be told
    // apart as either empty (same lap) or full (one lap apart).
    assign fifo.empty = (wr_ptr == rd_ptr);
    assign fifo.full  = (wr_ptr[3:0] == rd_ptr[3:0]) && (wr_ptr[4] != rd_ptr[4]);

    assign wr_acc   = fifo.write_enb && !fifo.full  && !fifo.soft_reset;
    assign rd_acc   = fifo.read_enb  && !fifo.empty && !fifo.soft_reset;
    assign rd_entry = mem[rd_ptr[3:0]];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (fifo.soft_reset) begin
            wr_ptr <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (wr_acc) begin
            mem[wr_ptr[3:0]] <= {fifo.lfd_state, fifo.data_in};
            wr_ptr           <= wr_ptr + 5'd1;
        end
    end

    // A header reload counts payload plus the trailing parity byte. The
    // output stays valid while bytes of a packet remain, so it only drops to
    // idle once the counter has run out and no read is taking place.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr    <= '0;
            pkt_count <= '0;
            data_q    <= '0;
            out_valid <= 1'b0;
        end else if (fifo.soft_reset) begin
            rd_ptr    <= '0;
            pkt_count <= '0;
            data_q    <= '0;
            out_valid <= 1'b0;
        end else if (rd_acc) begin
            rd_ptr    <= rd_ptr + 5'd1;
            data_q    <= rd_entry[7:0];
            out_valid <= 1'b1;
            if (rd_entry[8])
                pkt_count <= {1'b0, rd_entry[7:2]} + 7'd1;
            else if (pkt_count != 7'd0)
                pkt_count <= pkt_count - 7'd1;
        end else if (pkt_count == 7'd0) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ROUTER_FIFO_TRISTATE_EN
    assign fifo.data_out = out_valid ? data_q : 8'bz;
`else
    assign fifo.data_out = out_valid ? data_q : 8'h00;
`endif

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports as listed below.
REQ-002 Port clock, input, 1, sole clock, rising-edge active.
REQ-003 Port resetn, input, 1, asynchronous active-low reset.
REQ-004 Port soft_reset, input, 1, synchronous flush, driven by the sync stage on a 30-cycle read timeout.
REQ-005 Port write_enb, input, 1, write strobe, one bit of the sync stage's write_enb[2:0].
REQ-006 Port read_enb, input, 1, read strobe from the output port consumer.
REQ-007 Port lfd_state, input, 1, marks the current write word as a packet header.
REQ-008 Port data_in, input, 8, write data; for a header, bits[7:2] are payload length and bits[1:0] are the address.
REQ-009 Port data_out, output, 8, registered read data.
REQ-010 Port empty, output, 1, no stored words; feeds vld_out in the sync stage.
REQ-011 Port full, output, 1, 16 words stored.

Function
REQ-012 Storage SHALL be 16 entries x 9 bits: bit 8 holds the header flag (lfd_state at write) and bits[7:0] hold data_in.
REQ-013 The write pointer and read pointer SHALL each be 5 bits: the low 4 bits index storage and bit 4 is the wrap bit; both increment modulo 32.
REQ-014 empty SHALL be 1 when the pointers are equal, and full SHALL be 1 when the low 4 bits are equal and the wrap bits differ; both are combinational from the pointers.
REQ-015 A write SHALL be accepted on a clock edge iff write_enb=1, full=0, and soft_reset=0; it stores the entry and increments the write pointer.
REQ-016 A read SHALL be accepted on a clock edge iff read_enb=1, empty=0, and soft_reset=0; it increments the read pointer.
REQ-017 Simultaneous read and write SHALL both take effect when accepted.
- When full, only the read occurs; the write is dropped.
- When empty, only the write occurs.
- The count is unchanged when both occur.
REQ-018 Read latency SHALL be 1 cycle: data_out updates on the edge that accepts the read.
REQ-019 A 7-bit packet counter SHALL track remaining bytes.
- On an accepted read of an entry with flag=1, it loads data[7:2]+1 (payload plus parity).
- On an accepted read of an entry with flag=0 and counter≠0, it decrements.
- It never underflows; it holds at 0.
REQ-020 data_out priority at each edge SHALL be:
- soft_reset: idle value.
- Else, accepted read: stored data[7:0].
- Else, counter=0: idle value.
- Else: hold.
REQ-021 soft_reset=1 SHALL, on the clock edge, zero both pointers, the counter, and all 16 entries; data_out goes to idle; write and read are ignored that cycle.
REQ-022 The pointer wrap from 15 to 0 SHALL be seamless; full and empty remain correct across any number of wraps.

Reset
REQ-023 resetn=0 SHALL immediately, without waiting for a clock edge, clear both pointers, the counter, and all entries, and set data_out to idle.
- Resulting outputs: empty=1, full=0.
REQ-024 Reset asserted mid-packet SHALL discard all stored data, and no partial output SHALL follow deassertion.
REQ-025 After deassertion, the first write SHALL be accepted on the first rising clock edge with write_enb=1.

Configuration
REQ-026 With macro ROUTER_FIFO_TRISTATE_EN defined, the idle value of data_out SHALL be high impedance (8'bz) for a shared output bus.
REQ-027 Without ROUTER_FIFO_TRISTATE_EN, the idle value SHALL be 8'h00, and data_out SHALL never be z or x after reset.

Verification
REQ-028 Write header 8'h0D (length 3, addr 1) with lfd_state=1, then 8'hA1, A2, A3 and parity 8'h5F. Read 5 words. -> data_out is 0D, A1, A2, A3, 5F on consecutive edges, then idle on the next edge; empty=1.
REQ-029 Write 16 words with no reads -> full=1 after the 16th edge; a 17th write is dropped; reading 16 words returns the original 16 in order; empty=1.
REQ-030 Hold 8 words, then apply read_enb=1 and write_enb=1 together for 20 cycles -> full=0 and empty=0 throughout, the count stays 8, the pointers wrap, and the data order is preserved.
REQ-031 Hold 5 words, pulse soft_reset for 1 cycle with write_enb=1 -> empty=1, data_out is idle, the write is ignored, and a subsequent read returns only newly written data.
REQ-032 Assert resetn=0 between clock edges mid-packet -> empty=1, full=0, and data_out is idle before the next edge; after release, header 8'h04 round-trips correctly.
REQ-033 Run REQ-028 both with and without ROUTER_FIFO_TRISTATE_EN -> the idle value is 8'bz with the macro and 8'h00 without it.
